// File: rtl/button_code_encoder_if.sv
// Link from button_code_encoder toward the masterAXI input side, plus FSM
// visibility. outValid is a one-cycle pulse qualifying dataOut; there is no ready.
interface button_code_encoder_if;
    logic [1:0] dataOut;
    logic       outValid;
    logic       busy;
    logic [1:0] dbg_state;

    modport master (
        output dataOut,
        output outValid,
        output busy,
        output dbg_state
    );

    modport slave (
        input dataOut,
        input outValid,
        input busy,
        input dbg_state
    );
endinterface

// File: rtl/button_code_encoder.sv
// Debounces two raw push-buttons and emits each settled change as one outValid pulse.
// Optional auto-repeat of a held code is compiled in with BCE_AUTOREPEAT_EN.
module button_code_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SETTLE_CYCLES   = 1000,
    parameter int MIN_GAP_CYCLES  = 16,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [1:0]            btnIn,
    button_code_encoder_if.master bus
);

    localparam int DW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PMAX    = (SETTLE_CYCLES > MIN_GAP_CYCLES) ? SETTLE_CYCLES : MIN_GAP_CYCLES;
    localparam int PW      = $clog2(PMAX + 1);

    // Reject configurations that would break the pulse pacing at elaboration.
    if (DEBOUNCE_CYCLES < 2 || SETTLE_CYCLES < 1 || MIN_GAP_CYCLES < 1 ||
        REPEAT_CYCLES < MIN_GAP_CYCLES + 1) begin : g_bad_cfg
        $error("button_code_encoder: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_s1;
    logic [1:0]      r_s2;
    logic [1:0]      r_deb;
    logic [DW-1:0]   r_deb_cnt [2];
    logic [PW-1:0]   r_phase_cnt;
    logic [1:0]      r_last_sent;
    logic [1:0]      r_data_out;
    logic            r_out_valid;
    logic            w_rpt_fire;

    // Two-flop synchronizer; only r_s2 is used past this point.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= 2'b00;
            r_s2 <= 2'b00;
        end else begin
            r_s1 <= btnIn;
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_deb        <= 2'b00;
            r_deb_cnt[0] <= '0;
            r_deb_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    // This is the DEBOUNCE_CYCLES-th consecutive differing cycle.
                    r_deb[i]     <= r_s2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
                end
            end
        end
    end

`ifdef BCE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    logic [RW-1:0] r_rpt_cnt;
    logic          w_rpt_run;

    // Runs through GAP as well as IDLE so the repeat period is REPEAT_CYCLES + 1.
    assign w_rpt_run  = (r_deb == r_last_sent) && (r_deb != 2'b00) &&
                        (r_state != EMIT) && (r_state != SETTLE);
    assign w_rpt_fire = w_rpt_run && (r_rpt_cnt == RW'(REPEAT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rpt_cnt <= '0;
        end else if (!w_rpt_run) begin
            r_rpt_cnt <= '0;
        end else if (r_rpt_cnt != RW'(REPEAT_CYCLES - 1)) begin
            r_rpt_cnt <= r_rpt_cnt + RW'(1);
        end
    end
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (r_deb != r_last_sent) begin
                    w_next_state = SETTLE;
                end else if (w_rpt_fire) begin
                    w_next_state = EMIT;
                end
            end
            SETTLE: begin
                if (r_phase_cnt == PW'(SETTLE_CYCLES - 1)) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                w_next_state = GAP;
            end
            GAP: begin
                if (r_phase_cnt == PW'(MIN_GAP_CYCLES - 1)) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Shared SETTLE/GAP counter: zero on entry to every state, counts while dwelling.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_phase_cnt <= '0;
        end else if ((r_state == SETTLE) || (r_state == GAP)) begin
            r_phase_cnt <= r_phase_cnt + PW'(1);
        end
    end

    // dataOut and outValid are registered together, so the code is stable with its pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_data_out  <= 2'b00;
            r_last_sent <= 2'b00;
        end else begin
            r_out_valid <= (r_state == EMIT);
            if (r_state == EMIT) begin
                r_data_out  <= r_deb;
                r_last_sent <= r_deb;
            end
        end
    end

    assign bus.dataOut   = r_data_out;
    assign bus.outValid  = r_out_valid;
    assign bus.busy      = (r_state != IDLE);
    assign bus.dbg_state = r_state;

endmodule
